// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: excitation codes and the {J,K} derivation
// used by every counter built from JK cells.
package jk_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        CLR  = 2'b01,
        SET  = 2'b10,
        TGL  = 2'b11
    } jk_code_t;

    // Minimal excitation: only SET/CLR on a change, HOLD otherwise; TGL is never produced.
    function automatic jk_code_t jk_excite(input logic q, input logic n);
        return jk_code_t'({~q & n, q & ~n});
    endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control, status and excitation signals of the JK modulo counter.
// The master drives the controls; the slave (the counter) drives state and excitation.
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             load_err;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;

    modport master (
        output en, up, load, load_val,
        input  count, tc, load_err, j_vec, k_vec
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, load_err, j_vec, k_vec
    );
endinterface

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop with synchronous active-high reset.
module jk_ff_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignments so every cell samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case (jk_code_t'({j, k}))
                HOLD: q <= q;
                CLR:  q <= 1'b0;
                SET:  q <= 1'b1;
                TGL:  q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter whose state lives in JK cells; computes the next count,
// the per-bit J/K excitation, terminal count and the bad-load flag.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input logic             clk,
    input logic             reset,
    jk_mod_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    generate
        if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
            $error("jk_mod_counter: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             bad_load;
    logic             load_err_q;

    // Any value above MODULUS-1 is out of range; clamped to the top of the range.
    assign bad_load = bus.load_val > MAX;

    // NOTE: always_comb blocks assign a default first so no path leaves a signal unassigned (no latch).
    always_comb begin
        next_count = q;
        if (bus.load) begin
            next_count = bad_load ? MAX : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                next_count = (q == MAX) ? '0 : q + WIDTH'(1);
            end else begin
                next_count = (q == '0) ? MAX : q - WIDTH'(1);
            end
        end
    end

    // Excitation is forced to HOLD while reset is asserted.
    always_comb begin
        j = '0;
        k = '0;
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                {j[i], k[i]} = jk_excite(q[i], next_count[i]);
            end
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            jk_ff_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .j     (j[i]),
                .k     (k[i]),
                .q     (q[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= bus.load & bad_load;
        end
    end

    assign bus.count    = q;
    assign bus.j_vec    = j;
    assign bus.k_vec    = k;
    assign bus.load_err = load_err_q;
    assign bus.tc       = bus.en & ~bus.load &
                          ((bus.up & (q == MAX)) | (~bus.up & (q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: a decade counter (WIDTH=4, MODULUS=10)
// and a full-range counter (WIDTH=3, MODULUS=8) side by side.
module tb_jk_mod_counter;

    logic clk;
    logic reset_a;
    logic reset_b;
    int   checks;
    int   errors;

    jk_mod_counter_if #(.WIDTH(4)) bus_a ();
    jk_mod_counter_if #(.WIDTH(3)) bus_b ();

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a)
    );

    jk_mod_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // J and K must never both be high, and count must stay in range, on every cycle.
    always @(negedge clk) begin
        chk("jk_overlap_a", {28'd0, bus_a.j_vec & bus_a.k_vec}, 32'd0);
        chk("range_a", {31'd0, bus_a.count < 4'd10}, 32'd1);
        chk("jk_overlap_b", {29'd0, bus_b.j_vec & bus_b.k_vec}, 32'd0);
    end

    initial begin
        logic [3:0] c;
        logic [3:0] n;
        logic [2:0] cb;
        checks = 0;
        errors = 0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.en = 1'b0; bus_a.up = 1'b1; bus_a.load = 1'b0; bus_a.load_val = '0;
        bus_b.en = 1'b0; bus_b.up = 1'b1; bus_b.load = 1'b0; bus_b.load_val = '0;

        tick();
        chk("reset_count", {28'd0, bus_a.count}, 32'd0);
        chk("reset_load_err", {31'd0, bus_a.load_err}, 32'd0);
        chk("reset_j", {28'd0, bus_a.j_vec}, 32'd0);
        chk("reset_k", {28'd0, bus_a.k_vec}, 32'd0);

        // Up-count 0..9,0,1
        reset_a = 1'b0;
        bus_a.en = 1'b1;
        bus_a.up = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            c = 4'(i % 10);
            n = (c == 4'd9) ? 4'd0 : c + 4'd1;
            chk("up_count", {28'd0, bus_a.count}, {28'd0, c});
            chk("up_tc", {31'd0, bus_a.tc}, {31'd0, c == 4'd9});
            chk("up_j", {28'd0, bus_a.j_vec}, {28'd0, ~c & n});
            chk("up_k", {28'd0, bus_a.k_vec}, {28'd0, c & ~n});
            if (c == 4'd9) begin
                chk("wrap_j", {28'd0, bus_a.j_vec}, 32'h0);
                chk("wrap_k", {28'd0, bus_a.k_vec}, 32'h9);
            end
            tick();
        end
        chk("up_end", {28'd0, bus_a.count}, 32'd2);

        // Down-count from reset: 0,9,8,...
        reset_a = 1'b1;
        bus_a.en = 1'b0;
        tick();
        chk("down_reset", {28'd0, bus_a.count}, 32'd0);
        reset_a = 1'b0;
        bus_a.en = 1'b1;
        bus_a.up = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            c = 4'((10 - (i % 10)) % 10);
            chk("down_count", {28'd0, bus_a.count}, {28'd0, c});
            chk("down_tc", {31'd0, bus_a.tc}, {31'd0, c == 4'd0});
            tick();
        end
        chk("down_end", {28'd0, bus_a.count}, 32'd8);

        // Legal load, then out-of-range loads
        bus_a.en = 1'b0;
        bus_a.load = 1'b1;
        bus_a.load_val = 4'd7;
        tick();
        chk("load7_count", {28'd0, bus_a.count}, 32'd7);
        chk("load7_err", {31'd0, bus_a.load_err}, 32'd0);
        bus_a.load_val = 4'd12;
        tick();
        chk("load12_count", {28'd0, bus_a.count}, 32'd9);
        chk("load12_err", {31'd0, bus_a.load_err}, 32'd1);
        bus_a.load_val = 4'd15;
        tick();
        chk("load15_count", {28'd0, bus_a.count}, 32'd9);
        chk("load15_err", {31'd0, bus_a.load_err}, 32'd1);
        bus_a.load = 1'b0;
        tick();
        chk("err_clear", {31'd0, bus_a.load_err}, 32'd0);
        chk("hold_after_load", {28'd0, bus_a.count}, 32'd9);

        // Load with en: load wins, tc suppressed
        bus_a.load = 1'b1;
        bus_a.load_val = 4'd3;
        tick();
        chk("load3", {28'd0, bus_a.count}, 32'd3);
        bus_a.en = 1'b1;
        bus_a.up = 1'b1;
        bus_a.load_val = 4'd5;
        #1;
        chk("load_en_tc", {31'd0, bus_a.tc}, 32'd0);
        tick();
        chk("load_en_count", {28'd0, bus_a.count}, 32'd5);
        bus_a.en = 1'b0;
        bus_a.load_val = 4'd9;
        tick();
        chk("load9", {28'd0, bus_a.count}, 32'd9);
        bus_a.en = 1'b1;
        bus_a.load_val = 4'd2;
        #1;
        chk("load_at_term_tc", {31'd0, bus_a.tc}, 32'd0);
        chk("load_at_term_j", {28'd0, bus_a.j_vec}, 32'h2);
        chk("load_at_term_k", {28'd0, bus_a.k_vec}, 32'h9);
        tick();
        chk("load2", {28'd0, bus_a.count}, 32'd2);

        // Direction change with no dead cycle, then hold
        bus_a.load = 1'b0;
        bus_a.up = 1'b0;
        tick();
        chk("dir_down", {28'd0, bus_a.count}, 32'd1);
        bus_a.up = 1'b1;
        tick();
        chk("dir_up", {28'd0, bus_a.count}, 32'd2);
        bus_a.en = 1'b0;
        #1;
        chk("hold_j", {28'd0, bus_a.j_vec}, 32'd0);
        chk("hold_k", {28'd0, bus_a.k_vec}, 32'd0);
        tick();
        chk("hold_count", {28'd0, bus_a.count}, 32'd2);

        // Reset mid-count beats a simultaneous bad load
        bus_a.load = 1'b1;
        bus_a.load_val = 4'd6;
        tick();
        chk("load6", {28'd0, bus_a.count}, 32'd6);
        bus_a.load_val = 4'd14;
        bus_a.en = 1'b1;
        reset_a = 1'b1;
        #1;
        chk("rst_mid_j", {28'd0, bus_a.j_vec}, 32'd0);
        chk("rst_mid_k", {28'd0, bus_a.k_vec}, 32'd0);
        tick();
        chk("rst_mid_count", {28'd0, bus_a.count}, 32'd0);
        chk("rst_mid_err", {31'd0, bus_a.load_err}, 32'd0);
        reset_a = 1'b0;
        bus_a.load = 1'b0;
        tick();
        chk("resume_count", {28'd0, bus_a.count}, 32'd1);

        // Full-range counter: natural 7->0 overflow
        reset_b = 1'b0;
        bus_b.en = 1'b1;
        bus_b.up = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            cb = 3'(i % 8);
            chk("full_count", {29'd0, bus_b.count}, {29'd0, cb});
            chk("full_tc", {31'd0, bus_b.tc}, {31'd0, cb == 3'd7});
            if (cb == 3'd7) begin
                chk("full_wrap_j", {29'd0, bus_b.j_vec}, 32'h0);
                chk("full_wrap_k", {29'd0, bus_b.k_vec}, 32'h7);
            end
            tick();
        end
        chk("full_end", {29'd0, bus_b.count}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Synchronous modulo-N up/down counter whose state register is built from JK flip-flop cells, with per-bit J/K excitation logic computed from the current count and control inputs. It is the excitation stage that sits directly upstream of the JK cells and feeds their J/K inputs. It also exports those J/K vectors, so lab benches can observe excitation alongside state. Used as the standard counting/timebase block in the sequential-logic exercises.

## Interface
- WIDTH, 4, count width in bits; legal range 2..16
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high; clock clk
- en  in  1  count enable; one step per cycle while high
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous parallel load; priority over en
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current state (JK cell Q outputs)
- tc  out  1  terminal count, combinational
- load_err  out  1  registered one-cycle pulse: last load was out of range
- j_vec  out  WIDTH  J inputs presented to the cells this cycle
- k_vec  out  WIDTH  K inputs presented to the cells this cycle

## Operation
- Next-state priority: reset > load > en > hold.
- reset: every cell reset to 0; count=0, load_err=0.
- load with load_val < MODULUS: next = load_val, load_err=0.
- load with load_val >= MODULUS: next = MODULUS-1, load_err=1 for exactly one cycle.
- en && up: next = (count==MODULUS-1) ? 0 : count+1.
- en && !up: next = (count==0) ? MODULUS-1 : count-1.
- Otherwise next = count.
- Excitation per bit i, with q = count[i] and n = next[i]:
  - J = ~q & n
  - K = q & ~n
  - q==n yields the 00 hold code. Codes 01/10 only, never 11; the toggle code is not used.
- tc = en & ~load & ((up & count==MODULUS-1) | (~up & count==0)). It marks the cycle in which the wrap occurs.
- count is never outside 0..MODULUS-1, whatever the input sequence.
- During reset, j_vec and k_vec are driven to 0.

## Timing
- All state changes occur on the rising edge of clk. Latency from sampled load/en to the updated count is 1 cycle.
- tc and j_vec/k_vec are combinational from count and the controls, valid in the same cycle.
- load_err is asserted in the cycle following the offending load. It clears on the next edge unless another bad load occurs.
- Simultaneous load and en: load wins and tc=0.
- Direction change takes effect on the same edge it is sampled; no dead cycle.
- reset asserted mid-count: count=0 on the next edge. The first count step occurs on the edge after reset deasserts with en=1.
- MODULUS == 2^WIDTH: wrap is natural overflow; behaviour is identical to the general rules above.

## Structure
- Shared package jk_pkg:
  - JK code constants HOLD=2'b00, CLR=2'b01, SET=2'b10, TGL=2'b11.
  - A function returning the {J,K} pair from (q, next).
- One sub-module, jk_ff_cell: a single JK flip-flop with synchronous active-high reset, instantiated WIDTH times in a generate loop.
- Next-count logic, excitation and tc live in jk_mod_counter itself.
- Elaboration-time check: fail if MODULUS < 2 or MODULUS > 2^WIDTH.

## Test plan
- Reset then up-count, defaults, en=1, up=1 for 12 cycles -> count 0,1,…,9,0,1. tc=1 only while count=9. At the 9->0 step, j_vec=0000 and k_vec=1001.
- Down-count from reset, en=1, up=0 -> count 0,9,8,…; tc=1 in the cycles where count=0.
- Load legal and illegal: load_val=7 -> count=7, load_err=0. Then load_val=12 -> count=9 and load_err=1 for one cycle, then 0.
- Load and en together: count=3, load=1, load_val=5, en=1 -> count=5, tc=0.
- Reset mid-operation: count=6, en=1, reset pulsed one cycle -> count=0, load_err=0, j_vec=k_vec=0. Counting resumes 0->1 on the next enabled edge.
- Full-range modulus: WIDTH=3, MODULUS=8, up for 9 cycles -> count wraps 7->0 with tc=1 at 7. A self-checking monitor confirms j_vec & k_vec == 0 on every cycle.
